// File: rtl/parity_gen_tx.sv
// parity_gen_tx
// Generates even or odd parity for a 4-bit data nibble. The nibble arrives on a valid/ready
// handshake. The block presents the 5-bit word {a,b,c,d,e} in parallel to the downstream
// parity checker and also shifts the word out serially, one bit per clock.
//
// Parameters:
//   ODD_PARITY     0: a^b^c^d^e = 0, 1: a^b^c^d^e = 1
//   SER_MSB_FIRST  1: serial order a,b,c,d,e, 0: serial order e,d,c,b,a
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active-high
//   in_valid    in_data/inject_err valid this cycle
//   in_data     data nibble; [3]->a, [2]->b, [1]->c, [0]->d
//   inject_err  inverts the generated parity bit of the word being accepted
//   in_ready    block can accept a nibble this cycle (IDLE)
//   a..e        registered parallel word, e = parity bit, held until the next accept
//   word_valid  one-cycle pulse when a..e take a new word
//   ser_out     serial data bit
//   ser_valid   ser_out carries a frame bit
//   ser_last    marks the fifth (final) serial bit
//   frame_cnt   count of accepted frames, wraps 255->0
module parity_gen_tx #(
    parameter bit ODD_PARITY    = 1'b0,
    parameter bit SER_MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    input  logic       inject_err,
    output logic       in_ready,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       word_valid,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       ser_last,
    output logic [7:0] frame_cnt
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e     state;
    logic [2:0] bit_idx;
    // Bits still to be sent after the one currently on ser_out, next bit in [3].
    logic [3:0] shreg;

    logic       parity;
    logic [4:0] new_word;
    logic [4:0] ser_order;

    always_comb begin
        parity    = (^in_data) ^ ODD_PARITY ^ inject_err;
        new_word  = {in_data, parity};
        // ser_order[4] is the first bit on the wire.
        ser_order = SER_MSB_FIRST ? new_word
                                  : {new_word[0], new_word[1], new_word[2], new_word[3],
                                     new_word[4]};
    end

    // Ready is a function of the state register alone, so it carries no input path.
    assign in_ready = (state == StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            bit_idx    <= 3'd0;
            shreg      <= 4'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            c          <= 1'b0;
            d          <= 1'b0;
            e          <= 1'b0;
            word_valid <= 1'b0;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            ser_last   <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            word_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        {a, b, c, d, e} <= new_word;
                        shreg      <= ser_order[3:0];
                        ser_out    <= ser_order[4];
                        ser_valid  <= 1'b1;
                        ser_last   <= 1'b0;
                        bit_idx    <= 3'd0;
                        word_valid <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                        state      <= StShift;
                    end
                end
                StShift: begin
                    if (bit_idx == 3'd4) begin
                        state     <= StIdle;
                        bit_idx   <= 3'd0;
                        ser_out   <= 1'b0;
                        ser_valid <= 1'b0;
                        ser_last  <= 1'b0;
                    end else begin
                        bit_idx  <= bit_idx + 3'd1;
                        ser_out  <= shreg[3];
                        shreg    <= {shreg[2:0], 1'b0};
                        ser_last <= (bit_idx == 3'd3);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_gen_tx.sv
// Self-checking bench for parity_gen_tx. Two instances share all inputs: dut0 uses the
// default parameters (even parity, a-first), dut1 uses odd parity with e-first serial order.
// Expected words are pushed to per-instance queues when a nibble is driven and popped when
// the instance pulses word_valid.
module tb_parity_gen_tx;

    typedef struct packed {
        logic [4:0] word;   // {a,b,c,d,e}
        logic [4:0] ser;    // [4] is the first serial bit
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       inject_err = 1'b0;

    logic       in_ready0, a0, b0, c0, d0, e0, wv0, so0, sv0, sl0;
    logic [7:0] fc0;
    logic       in_ready1, a1, b1, c1, d1, e1, wv1, so1, sv1, sl1;
    logic [7:0] fc1;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] cnt_m = 8'd0;

    parity_gen_tx #(.ODD_PARITY(1'b0), .SER_MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .inject_err(inject_err), .in_ready(in_ready0), .a(a0), .b(b0), .c(c0), .d(d0),
        .e(e0), .word_valid(wv0), .ser_out(so0), .ser_valid(sv0), .ser_last(sl0),
        .frame_cnt(fc0)
    );

    parity_gen_tx #(.ODD_PARITY(1'b1), .SER_MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .inject_err(inject_err), .in_ready(in_ready1), .a(a1), .b(b1), .c(c1), .d(d1),
        .e(e1), .word_valid(wv1), .ser_out(so1), .ser_valid(sv1), .ser_last(sl1),
        .frame_cnt(fc1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [3:0] dd, input logic inj, input logic odd,
                                   input logic msb, input logic [7:0] cnt);
        exp_t r;
        logic p;
        p      = dd[3] ^ dd[2] ^ dd[1] ^ dd[0] ^ odd ^ inj;
        r.word = {dd, p};
        r.ser  = msb ? r.word : {r.word[0], r.word[1], r.word[2], r.word[3], r.word[4]};
        r.cnt  = cnt;
        return r;
    endfunction

    task automatic push(input logic [3:0] dd, input logic inj);
        cnt_m = cnt_m + 8'd1;
        q0.push_back(model(dd, inj, 1'b0, 1'b1, cnt_m));
        q1.push_back(model(dd, inj, 1'b1, 1'b0, cnt_m));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cnt_m = 8'd0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete frame: accept, five serial bits, return to IDLE.
    task automatic run_frame(input logic [3:0] dd, input logic inj, input string name);
        exp_t x0, x1;
        x0 = '0;
        x1 = '0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = dd;
        inject_err = inj;
        push(dd, inj);
        @(posedge clk);
        #1;
        // Inputs are don't-care during SHIFT; scramble them to show they are ignored.
        in_valid = 1'($urandom);
        in_data = 4'($urandom);
        inject_err = 1'($urandom);
        n_cmp++;
        if (wv0 !== 1'b1 || wv1 !== 1'b1) begin
            n_bad++;
            $display("FAIL %s word_valid: got %b/%b want 1/1", name, wv0, wv1);
        end
        n_cmp++;
        if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
            n_bad++;
            $display("FAIL %s in_ready_busy: got %b/%b want 0/0", name, in_ready0, in_ready1);
        end
        if (q0.size() == 0 || q1.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s scoreboard: got empty queue want entry", name);
        end else begin
            x0 = q0.pop_front();
            x1 = q1.pop_front();
        end
        n_cmp++;
        if ({a0, b0, c0, d0, e0} !== x0.word) begin
            n_bad++;
            $display("FAIL %s word0: got %b want %b", name, {a0, b0, c0, d0, e0}, x0.word);
        end
        n_cmp++;
        if ({a1, b1, c1, d1, e1} !== x1.word) begin
            n_bad++;
            $display("FAIL %s word1: got %b want %b", name, {a1, b1, c1, d1, e1}, x1.word);
        end
        n_cmp++;
        if (fc0 !== x0.cnt || fc1 !== x1.cnt) begin
            n_bad++;
            $display("FAIL %s frame_cnt: got %0d/%0d want %0d", name, fc0, fc1, x0.cnt);
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                n_cmp++;
                if (wv0 !== 1'b0 || wv1 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s word_valid_pulse: got %b/%b want 0/0", name, wv0, wv1);
                end
            end
            n_cmp++;
            if ({so0, sv0, sl0} !== {x0.ser[4-k], 1'b1, (k == 4)}) begin
                n_bad++;
                $display("FAIL %s ser0 bit %0d: got out/valid/last %b%b%b want %b%b%b", name,
                         k, so0, sv0, sl0, x0.ser[4-k], 1'b1, (k == 4));
            end
            n_cmp++;
            if ({so1, sv1, sl1} !== {x1.ser[4-k], 1'b1, (k == 4)}) begin
                n_bad++;
                $display("FAIL %s ser1 bit %0d: got out/valid/last %b%b%b want %b%b%b", name,
                         k, so1, sv1, sl1, x1.ser[4-k], 1'b1, (k == 4));
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        n_cmp++;
        if ({in_ready0, sv0, sl0, in_ready1, sv1, sl1} !== 6'b100_100) begin
            n_bad++;
            $display("FAIL %s idle_after: got rdy/sv/sl %b%b%b %b%b%b want 100 100", name,
                     in_ready0, sv0, sl0, in_ready1, sv1, sl1);
        end
        n_cmp++;
        if ({a0, b0, c0, d0, e0} !== x0.word || {a1, b1, c1, d1, e1} !== x1.word) begin
            n_bad++;
            $display("FAIL %s word_hold: got %b/%b want %b/%b", name, {a0, b0, c0, d0, e0},
                     {a1, b1, c1, d1, e1}, x0.word, x1.word);
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({in_ready0, a0, b0, c0, d0, e0, wv0, so0, sv0, sl0} !== 10'b1_00000_0000
            || fc0 !== 8'd0 || in_ready1 !== 1'b1 || sv1 !== 1'b0 || fc1 !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_state: got rdy=%b word=%b wv=%b so/sv/sl=%b%b%b cnt=%0d want 1 00000 0 000 0",
                     in_ready0, {a0, b0, c0, d0, e0}, wv0, so0, sv0, sl0, fc0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready0 !== 1'b1 || sv0 !== 1'b0 || fc0 !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_release: got rdy=%b sv=%b cnt=%0d want 1 0 0", in_ready0, sv0,
                     fc0);
        end
    endtask

    task automatic test_basic();
        run_frame(4'b1011, 1'b0, "basic_1011");
    endtask

    task automatic test_inject();
        run_frame(4'b0110, 1'b1, "inject_on");
        n_cmp++;
        if (e0 !== 1'b1 || (a0 ^ b0 ^ c0 ^ d0 ^ e0) !== 1'b1) begin
            n_bad++;
            $display("FAIL inject_on_e: got e=%b want 1", e0);
        end
        run_frame(4'b0110, 1'b0, "inject_off");
        n_cmp++;
        if (e0 !== 1'b0) begin
            n_bad++;
            $display("FAIL inject_off_e: got e=%b want 0", e0);
        end
    endtask

    task automatic test_odd_lsb();
        run_frame(4'b0000, 1'b0, "odd_0000");
        n_cmp++;
        if (e1 !== 1'b1) begin
            n_bad++;
            $display("FAIL odd_0000_e: got e=%b want 1", e1);
        end
        run_frame(4'b1000, 1'b0, "lsb_first_1000");
    endtask

    task automatic test_back_to_back();
        exp_t x0, x1;
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 4'h3;
        inject_err = 1'b0;
        push(4'h3, 1'b0);
        for (int f = 0; f < 2; f++) begin
            @(posedge clk);
            #1;
            x0 = '0;
            x1 = '0;
            n_cmp++;
            if (wv0 !== 1'b1 || wv1 !== 1'b1 || q0.size() == 0 || q1.size() == 0) begin
                n_bad++;
                $display("FAIL b2b accept %0d: got wv=%b/%b want 1/1", f, wv0, wv1);
            end else begin
                x0 = q0.pop_front();
                x1 = q1.pop_front();
            end
            n_cmp++;
            if ({a0, b0, c0, d0, e0} !== x0.word || {a1, b1, c1, d1, e1} !== x1.word
                || fc0 !== x0.cnt || fc1 !== x1.cnt) begin
                n_bad++;
                $display("FAIL b2b word %0d: got %b/%b cnt %0d want %b/%b cnt %0d", f,
                         {a0, b0, c0, d0, e0}, {a1, b1, c1, d1, e1}, fc0, x0.word, x1.word,
                         x0.cnt);
            end
            if (f == 0) begin
                in_data = 4'hC;
                push(4'hC, 1'b0);
                for (int cyc = 1; cyc <= 5; cyc++) begin
                    @(posedge clk);
                    #1;
                    n_cmp++;
                    if (wv0 !== 1'b0 || wv1 !== 1'b0 || {a0, b0, c0, d0, e0} !== x0.word) begin
                        n_bad++;
                        $display("FAIL b2b ignored cyc %0d: got wv=%b word=%b want 0 %b", cyc,
                                 wv0, {a0, b0, c0, d0, e0}, x0.word);
                    end
                end
                n_cmp++;
                if (in_ready0 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b ready_n5: got %b want 1", in_ready0);
                end
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (fc0 !== 8'd2 || e0 !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b final: got cnt=%0d e=%b want 2 0", fc0, e0);
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b drain: got rdy=%b/%b want 1/1", in_ready0, in_ready1);
        end
    endtask

    task automatic test_async_reset();
        exp_t x0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 4'b1101;
        inject_err = 1'b0;
        push(4'b1101, 1'b0);
        x0 = q0[$];
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++;
        if (so0 !== x0.ser[2] || sv0 !== 1'b1) begin
            n_bad++;
            $display("FAIL arst third_bit: got %b/%b want %b/1", so0, sv0, x0.ser[2]);
        end
        #2;
        rst = 1'b1;
        cnt_m = 8'd0;
        q0.delete();
        q1.delete();
        #1;
        n_cmp++;
        if ({in_ready0, sv0, sl0, so0, wv0, a0, b0, c0, d0, e0} !== 10'b1000_0_00000
            || fc0 !== 8'd0 || in_ready1 !== 1'b1 || sv1 !== 1'b0 || fc1 !== 8'd0) begin
            n_bad++;
            $display("FAIL arst immediate: got rdy=%b sv=%b word=%b cnt=%0d want 1 0 00000 0",
                     in_ready0, sv0, {a0, b0, c0, d0, e0}, fc0);
        end
        @(negedge clk);
        rst = 1'b0;
        run_frame(4'b0101, 1'b0, "after_arst");
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            run_frame(4'($urandom), 1'($urandom), "wrap");
            if (i == 255) begin
                n_cmp++;
                if (fc0 !== 8'd255 || fc1 !== 8'd255) begin
                    n_bad++;
                    $display("FAIL wrap_255: got %0d/%0d want 255", fc0, fc1);
                end
            end
            if (i == 256) begin
                n_cmp++;
                if (fc0 !== 8'd0 || fc1 !== 8'd0) begin
                    n_bad++;
                    $display("FAIL wrap_256: got %0d/%0d want 0", fc0, fc1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inject();
        test_odd_lsb();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
